// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arb_pkg
// Brief    : Shared types and constants for the data-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    localparam int DMEM_AW = 32;
    localparam int DMEM_DW = 32;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

endpackage
`default_nettype wire

// File: rtl/arb_pick2.sv
`default_nettype none
// ============================================================================
// Module   : arb_pick2
// Brief    : Two-way one-hot picker; round-robin when DMEM_ARB_RR_EN is
//            defined, otherwise fixed priority with port 0 on top.
// Revision : 1.0 - initial release
// ============================================================================
module arb_pick2
    import dmem_arb_pkg::*;
(
    input  logic       req0_i,
    input  logic       req1_i,
    input  logic       last_owner_i,
    output logic [1:0] gnt_o
);

`ifdef DMEM_ARB_RR_EN
    always_comb begin
        gnt_o = 2'b00;
        if (req0_i && req1_i) begin
            // On contention the port that did not win last time goes next
            gnt_o = (last_owner_i == OWN_DBG) ? 2'b01 : 2'b10;
        end else if (req0_i) begin
            gnt_o = 2'b01;
        end else if (req1_i) begin
            gnt_o = 2'b10;
        end
    end
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner_i;

    always_comb begin
        gnt_o = 2'b00;
        if (req0_i) begin
            gnt_o = 2'b01;
        end else if (req1_i) begin
            gnt_o = 2'b10;
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Two-port data-memory arbiter (CPU / debug loader), one access
//            every two cycles. Build option: DMEM_ARB_RR_EN (round-robin).
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW = DMEM_AW,
    parameter int DW = DMEM_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          err0,
    output logic          err1,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_wd,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rd
);

    state_e        state_q, state_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          owner_q, owner_d;
    logic          ack0_q, ack0_d, ack1_q, ack1_d;
    logic          err0_q, err0_d, err1_q, err1_d;
    logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic [1:0]    w_pick;
    logic [1:0]    w_gnt;
    logic          w_last;
    logic          w_mis;
    logic [DW-1:0] w_rd;

`ifdef DMEM_ARB_RR_EN
    logic last_q, last_d;
    assign w_last = last_q;
`else
    assign w_last = OWN_DBG;
`endif

    arb_pick2 u_pick (
        .req0_i       (req0),
        .req1_i       (req1),
        .last_owner_i (w_last),
        .gnt_o        (w_pick)
    );

    assign w_gnt = (reset && state_q == ST_IDLE) ? w_pick : 2'b00;
    assign gnt0  = w_gnt[0];
    assign gnt1  = w_gnt[1];

    assign w_mis = (addr_q[1:0] != 2'b00);
    assign w_rd  = (we_q || w_mis) ? '0 : mem_rd;

    // Address/data simply hold the last latched command outside BUSY
    assign mem_address = addr_q;
    assign mem_wd      = wdata_q;
    assign mem_we      = (state_q == ST_BUSY) && we_q && !w_mis && reset;

    assign ack0   = ack0_q;
    assign ack1   = ack1_q;
    assign err0   = err0_q;
    assign err1   = err1_q;
    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        owner_d  = owner_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        err0_d   = 1'b0;
        err1_d   = 1'b0;
        rdata0_d = '0;
        rdata1_d = '0;
`ifdef DMEM_ARB_RR_EN
        last_d   = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (w_gnt != 2'b00) begin
                    state_d = ST_BUSY;
                    owner_d = w_gnt[1] ? OWN_DBG : OWN_CPU;
                    we_d    = w_gnt[1] ? we1    : we0;
                    addr_d  = w_gnt[1] ? addr1  : addr0;
                    wdata_d = w_gnt[1] ? wdata1 : wdata0;
`ifdef DMEM_ARB_RR_EN
                    last_d  = owner_d;
`endif
                end
            end
            ST_BUSY: begin
                state_d = ST_IDLE;
                if (owner_q == OWN_CPU) begin
                    ack0_d   = 1'b1;
                    err0_d   = w_mis;
                    rdata0_d = w_rd;
                end else begin
                    ack1_d   = 1'b1;
                    err1_d   = w_mis;
                    rdata1_d = w_rd;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            owner_q  <= OWN_CPU;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
`ifdef DMEM_ARB_RR_EN
            last_q   <= OWN_DBG;
`endif
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            owner_q  <= owner_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            err0_q   <= err0_d;
            err1_q   <= err1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
`ifdef DMEM_ARB_RR_EN
            last_q   <= last_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Self-checking bench for dmem_arbiter with a transaction-level
//            reference model and a behavioural 64-word data memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, ack0, ack1, err0, err1, mem_we;
    logic [DW-1:0] rdata0, rdata1, mem_wd, mem_rd;
    logic [AW-1:0] mem_address;

    dmem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
        .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
        .mem_address(mem_address), .mem_wd(mem_wd), .mem_we(mem_we),
        .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] init_word(input int i);
        return 32'hC0DE0000 + i;
    endfunction

    // Behavioural data memory seen by the DUT
    logic          tb_load = 1'b1;
    logic [DW-1:0] tbmem [64];
    assign mem_rd = tbmem[mem_address[7:2]];
    always @(posedge clk) begin
        if (tb_load) begin
            for (int i = 0; i < 64; i++) tbmem[i] <= init_word(i);
        end else if (mem_we) begin
            tbmem[mem_address[7:2]] <= mem_wd;
        end
    end

    // Reference model: one outstanding command, one response slot
    logic [DW-1:0] exp_mem [64];
    logic          m_busy = 1'b0, m_we = 1'b0, m_port = 1'b0, m_last = 1'b1;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic          m_ack0 = 1'b0, m_ack1 = 1'b0, m_err0 = 1'b0, m_err1 = 1'b0;
    logic [DW-1:0] m_rd0 = '0, m_rd1 = '0;
    logic          g0_seen = 1'b0, g1_seen = 1'b0;

    function automatic int winner(input logic r0, input logic r1, input logic last);
        if (r0 && r1) begin
`ifdef DMEM_ARB_RR_EN
            return (last == 1'b1) ? 0 : 1;
`else
            return (last == 1'b1) ? 0 : 0;
`endif
        end
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    always @(negedge clk) begin
        int  w;
        logic mis;
        logic e_g0, e_g1, e_we;
        g0_seen = gnt0;
        g1_seen = gnt1;
        if (tb_load) begin
            for (int i = 0; i < 64; i++) exp_mem[i] = init_word(i);
        end
        w    = winner(req0, req1, m_last);
        e_g0 = reset && !m_busy && (w == 0);
        e_g1 = reset && !m_busy && (w == 1);
        mis  = (m_addr[1:0] != 2'b00);
        e_we = m_busy && m_we && !mis && reset;
        chk("gnt0", gnt0, e_g0);
        chk("gnt1", gnt1, e_g1);
        chk("mem_we", mem_we, e_we);
        if (m_busy) begin
            chk("mem_address", mem_address, m_addr);
            chk("mem_wd", mem_wd, m_wdata);
        end
        chk("ack0", ack0, m_ack0);
        chk("ack1", ack1, m_ack1);
        chk("err0", err0, m_err0);
        chk("err1", err1, m_err1);
        chk("rdata0", rdata0, m_rd0);
        chk("rdata1", rdata1, m_rd1);

        // Advance the model across the coming edge
        if (!reset) begin
            m_busy = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_last = 1;
            m_ack0 = 0; m_ack1 = 0; m_err0 = 0; m_err1 = 0; m_rd0 = '0; m_rd1 = '0;
        end else if (m_busy) begin
            m_ack0 = (m_port == 0); m_ack1 = (m_port == 1);
            m_err0 = m_ack0 && mis; m_err1 = m_ack1 && mis;
            m_rd0 = (m_ack0 && !m_we && !mis) ? exp_mem[m_addr[7:2]] : '0;
            m_rd1 = (m_ack1 && !m_we && !mis) ? exp_mem[m_addr[7:2]] : '0;
            if (m_we && !mis) exp_mem[m_addr[7:2]] = m_wdata;
            m_busy = 0;
        end else begin
            m_ack0 = 0; m_ack1 = 0; m_err0 = 0; m_err1 = 0; m_rd0 = '0; m_rd1 = '0;
            if (w >= 0) begin
                m_busy  = 1;
                m_port  = (w == 1);
                m_we    = (w == 1) ? we1 : we0;
                m_addr  = (w == 1) ? addr1 : addr0;
                m_wdata = (w == 1) ? wdata1 : wdata0;
                m_last  = (w == 1);
            end
        end
    end

    task automatic issue(input int port, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, output logic [DW-1:0] rd,
                         output logic er, output int lat);
        int t0;
        bit got;
        rd = 'x; er = 1'bx; lat = -1; t0 = 0;
        @(posedge clk); #1;
        if (port == 0) begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
        else           begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if ((port == 0) ? gnt0 : gnt1) begin got = 1; t0 = cyc; end
        end
        if (!got) chk("grant_timeout", 0, 1);
        @(posedge clk); #1;
        req0 = (port == 0) ? 1'b0 : req0;
        req1 = (port == 1) ? 1'b0 : req1;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if ((port == 0) ? ack0 : ack1) begin
                got = 1;
                rd  = (port == 0) ? rdata0 : rdata1;
                er  = (port == 0) ? err0 : err1;
                lat = cyc - t0;
            end
        end
        if (!got) chk("ack_timeout", 0, 1);
    endtask

    function automatic logic [AW-1:0] rand_addr();
        logic [1:0] lo;
        lo = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        return {24'b0, 6'($urandom_range(0, 63)), lo};
    endfunction

    initial begin
        logic [DW-1:0] rd;
        logic          er;
        int            lat, n, cnt_g1, cnt_a1, cnt_a0;
        int            seq [8];
        int            tms [8];
        bit            got;

        repeat (3) @(posedge clk);
        #1 tb_load = 0;
        @(posedge clk); #1 reset = 1;
        @(negedge clk);
        chk("reset_rdata0", rdata0, 32'h0);
        chk("reset_ack0", ack0, 1'b0);

        // Contention right after reset: grants alternate (RR) or stay on port 0
        @(posedge clk); #1;
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 32'h10; addr1 = 32'h14;
        n = 0;
        for (int i = 0; i < 40 && n < 8; i++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin seq[n] = gnt1 ? 1 : 0; tms[n] = cyc; n++; end
        end
        @(posedge clk); #1 req0 = 0; req1 = 0;
        chk("contention_count", n, 8);
        for (int i = 0; i < 8; i++) begin
`ifdef DMEM_ARB_RR_EN
            chk("contention_winner", seq[i], i % 2);
`else
            chk("contention_winner", seq[i], 0);
`endif
            if (i > 0) chk("contention_spacing", tms[i] - tms[i-1], 2);
        end
        repeat (3) @(posedge clk);

        // Write then read back on port 0
        issue(0, 1, 32'h10, 32'hDEADBEEF, rd, er, lat);
        chk("wr_err", er, 1'b0);
        chk("wr_latency", lat, 2);
        issue(0, 0, 32'h10, 32'h0, rd, er, lat);
        chk("rd_data", rd, 32'hDEADBEEF);
        chk("rd_err", er, 1'b0);
        chk("rd_latency", lat, 2);

        // Misaligned write on port 1
        issue(1, 1, 32'h13, 32'h55AA55AA, rd, er, lat);
        chk("mis_err", er, 1'b1);
        chk("mis_rdata", rd, 32'h0);
        issue(0, 0, 32'h10, 32'h0, rd, er, lat);
        chk("mis_no_side_effect", rd, 32'hDEADBEEF);
        issue(1, 0, 32'h20, 32'h0, rd, er, lat);
        chk("p1_read_init", rd, 32'hC0DE0008);

        // Reset asserted during BUSY of a write
        @(posedge clk); #1;
        req0 = 1; we0 = 1; addr0 = 32'h20; wdata0 = 32'h1234;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (gnt0) got = 1;
        end
        if (!got) chk("rst_grant_timeout", 0, 1);
        @(posedge clk); #1 reset = 0; req0 = 0;
        @(negedge clk);
        chk("rst_busy_we", mem_we, 1'b0);
        @(posedge clk); #1 reset = 1;
        cnt_a0 = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ack0) cnt_a0++;
        end
        chk("rst_no_ack", cnt_a0, 0);
        @(posedge clk); #1;
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 32'h20; addr1 = 32'h24;
        @(negedge clk);
        chk("rst_first_winner0", gnt0, 1'b1);
        chk("rst_first_winner1", gnt1, 1'b0);
        @(posedge clk); #1 req0 = 0; req1 = 0;
        repeat (3) @(posedge clk);
        issue(0, 0, 32'h20, 32'h0, rd, er, lat);
        chk("rst_no_commit", rd, 32'hC0DE0008);

        // Port 1 withdraws its request while port 0 is in BUSY
        @(posedge clk); #1;
        req0 = 1; we0 = 1; addr0 = 32'h30; wdata0 = 32'hCAFEF00D;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (gnt0) got = 1;
        end
        if (!got) chk("drop_grant_timeout", 0, 1);
        @(posedge clk); #1;
        req0 = 0; req1 = 1; we1 = 1; addr1 = 32'h30; wdata1 = 32'h11111111;
        cnt_g1 = 0; cnt_a1 = 0;
        @(negedge clk);
        if (gnt1) cnt_g1++;
        @(posedge clk); #1 req1 = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (gnt1) cnt_g1++;
            if (ack1) cnt_a1++;
        end
        chk("drop_no_gnt1", cnt_g1, 0);
        chk("drop_no_ack1", cnt_a1, 0);
        issue(0, 0, 32'h30, 32'h0, rd, er, lat);
        chk("drop_mem", rd, 32'hCAFEF00D);

        // Randomized traffic with occasional withdrawals and resets
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            reset = ($urandom_range(0, 99) != 0);
            if (!req0 || g0_seen) begin
                req0 = ($urandom_range(0, 2) != 0); we0 = 1'($urandom_range(0, 1));
                addr0 = rand_addr(); wdata0 = $urandom;
            end else if ($urandom_range(0, 19) == 0) begin
                req0 = 0;
            end
            if (!req1 || g1_seen) begin
                req1 = ($urandom_range(0, 2) != 0); we1 = 1'($urandom_range(0, 1));
                addr1 = rand_addr(); wdata1 = $urandom;
            end else if ($urandom_range(0, 19) == 0) begin
                req1 = 0;
            end
        end
        @(posedge clk); #1 req0 = 0; req1 = 0; reset = 1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 64; i++) chk("final_mem", tbmem[i], exp_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
